// File: rtl/pet_io_pkg.sv
// Shared constants for the PET I/O hub: IRQ register map,
// unmapped read value and slot-count limit.
package pet_io_pkg;

  typedef enum logic [1:0] {
    IRQ_PEND  = 2'd0,
    IRQ_MASK  = 2'd1,
    IRQ_MODE  = 2'd2,
    IRQ_CLEAR = 2'd3
  } irq_reg_e;

  localparam logic [7:0] UNMAPPED_DATA = 8'hFF;
  localparam int         MAX_DEV       = 8;

endpackage

// File: rtl/pet_io_irqctl.sv
// Interrupt controller: per-source mask, level/edge mode,
// edge-pending latch with write-1-to-clear, registered irq.
module pet_io_irqctl
  import pet_io_pkg::*;
#(
  parameter int NUM_DEV = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [1:0]         reg_sel,
  input  logic [7:0]         wdata,
  input  logic [NUM_DEV-1:0] dev_irq,
  output logic               irq,
  output logic [7:0]         rdata
);

  logic [NUM_DEV-1:0] mask_q, mask_d;
  logic [NUM_DEV-1:0] mode_q, mode_d;
  logic [NUM_DEV-1:0] epend_q, epend_d;
  logic [NUM_DEV-1:0] prev_q;
  logic [NUM_DEV-1:0] clr, rise, pending;
  logic               irq_q, irq_d;

  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    clr    = '0;
    if (wr_en) begin
      unique case (irq_reg_e'(reg_sel))
        IRQ_PEND:  ;
        IRQ_MASK:  mask_d = wdata[NUM_DEV-1:0];
        IRQ_MODE:  mode_d = wdata[NUM_DEV-1:0];
        IRQ_CLEAR: clr    = wdata[NUM_DEV-1:0];
      endcase
    end
    rise = dev_irq & ~prev_q;
    // set beats clear; leaving edge mode drops the latched bit
    epend_d = ((epend_q & ~clr) | rise) & mode_d;
    pending = (dev_irq & ~mode_q) | epend_q;
    irq_d   = |(((dev_irq & ~mode_d) | epend_d) & mask_d);
  end

  always_comb begin
    rdata = '0;
    unique case (irq_reg_e'(reg_sel))
      IRQ_PEND:  rdata[NUM_DEV-1:0] = pending;
      IRQ_MASK:  rdata[NUM_DEV-1:0] = mask_q;
      IRQ_MODE:  rdata[NUM_DEV-1:0] = mode_q;
      IRQ_CLEAR: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= '1;
      mode_q  <= '0;
      epend_q <= '0;
      prev_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      epend_q <= epend_d;
      prev_q  <= dev_irq;
      irq_q   <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: rtl/pet_io_hub.sv
// PET I/O region hub: one-hot slot decode, latency-programmable read
// pipeline with rdy wait, IRQ controller. PET_IO_OPENBUS_EN: open-bus latch.
module pet_io_hub
  import pet_io_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int ADDR_W  = 11,
  parameter int SLOT_AW = 4,
  parameter int RD_LAT  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic [ADDR_W-1:0]    addr,
  input  logic                 we,
  input  logic [7:0]           data_in,
  output logic [7:0]           data_out,
  output logic                 rdy,
  output logic                 irq,
  output logic [NUM_DEV-1:0]   dev_strobe,
  output logic                 dev_we,
  output logic [SLOT_AW-1:0]   dev_addr,
  output logic [7:0]           dev_wdata,
  input  logic [8*NUM_DEV-1:0] dev_rdata,
  input  logic [NUM_DEV-1:0]   dev_irq
);

  localparam int HB_W = ADDR_W - SLOT_AW;

  if (NUM_DEV < 1 || NUM_DEV > MAX_DEV || NUM_DEV > HB_W ||
      RD_LAT < 1 || RD_LAT > 4) begin : g_bad_cfg
    $error("pet_io_hub: illegal parameter set");
  end

  logic [HB_W-1:0]    hb;
  logic [NUM_DEV-1:0] hit;
  logic               accepted;
  logic [7:0]         and_data, rd_data, open_data, irq_rdata;
  logic [1:0]         cnt_q, cnt_d;
  logic [7:0]         hold_q, hold_d;
  logic [7:0]         dout_q, dout_d;

  assign hb         = addr[ADDR_W-1:SLOT_AW];
  assign hit        = hb[NUM_DEV-1:0];
  assign rdy        = (cnt_q == 2'd0);
  assign accepted   = ce & rdy;
  assign dev_strobe = {NUM_DEV{accepted}} & hit;
  assign dev_we     = we;
  assign dev_addr   = addr[SLOT_AW-1:0];
  assign dev_wdata  = data_in;

  pet_io_irqctl #(.NUM_DEV(NUM_DEV)) u_irqctl (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (accepted & we & (hb == '0)),
    .reg_sel (addr[1:0]),
    .wdata   (data_in),
    .dev_irq (dev_irq),
    .irq     (irq),
    .rdata   (irq_rdata)
  );

  // aliased slots wire-AND their read data
  always_comb begin
    and_data = 8'hFF;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (hit[i]) and_data = and_data & dev_rdata[8*i +: 8];
    end
    if (|hit)            rd_data = and_data;
    else if (hb == '0)   rd_data = irq_rdata;
    else                 rd_data = open_data;
  end

  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    dout_d = dout_q;
    if (accepted && !we) begin
      if (RD_LAT == 1) begin
        dout_d = rd_data;
      end else begin
        hold_d = rd_data;
        cnt_d  = 2'(RD_LAT - 1);
      end
    end else if (cnt_q == 2'd1) begin
      dout_d = hold_q;
      cnt_d  = 2'd0;
    end else if (cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= 2'd0;
      hold_q <= UNMAPPED_DATA;
      dout_q <= UNMAPPED_DATA;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      dout_q <= dout_d;
    end
  end

  assign data_out = dout_q;

`ifdef PET_IO_OPENBUS_EN
  logic [7:0] bus_q, bus_d;
  logic       rd_done;

  assign rd_done = (RD_LAT == 1) ? (accepted & ~we) : (cnt_q == 2'd1);

  always_comb begin
    bus_d = bus_q;
    if (accepted && we) bus_d = data_in;
    else if (rd_done)   bus_d = dout_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bus_q <= UNMAPPED_DATA;
    else          bus_q <= bus_d;
  end

  assign open_data = bus_q;
`else
  assign open_data = UNMAPPED_DATA;
`endif

endmodule

// File: tb/tb_pet_io_hub.sv
// Directed bench for pet_io_hub: one instance with RD_LAT=1 and one
// with RD_LAT=3 share the stimulus; each test checks the relevant one.
module tb_pet_io_hub;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ce;
  logic [10:0] addr;
  logic        we;
  logic [7:0]  data_in;
  logic [31:0] dev_rdata;
  logic [3:0]  dev_irq;

  logic [7:0] d1_dout, d3_dout, d1_wdata, d3_wdata;
  logic       d1_rdy, d3_rdy, d1_irq, d3_irq, d1_we, d3_we;
  logic [3:0] d1_stb, d3_stb, d1_daddr, d3_daddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pet_io_hub #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .addr(addr), .we(we),
    .data_in(data_in), .data_out(d1_dout), .rdy(d1_rdy), .irq(d1_irq),
    .dev_strobe(d1_stb), .dev_we(d1_we), .dev_addr(d1_daddr),
    .dev_wdata(d1_wdata), .dev_rdata(dev_rdata), .dev_irq(dev_irq)
  );

  pet_io_hub #(.RD_LAT(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .ce(ce), .addr(addr), .we(we),
    .data_in(data_in), .data_out(d3_dout), .rdy(d3_rdy), .irq(d3_irq),
    .dev_strobe(d3_stb), .dev_we(d3_we), .dev_addr(d3_daddr),
    .dev_wdata(d3_wdata), .dev_rdata(dev_rdata), .dev_irq(dev_irq)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    ce = 1'b0;
    we = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [10:0] a, input logic [7:0] d);
    addr = a; data_in = d; we = 1'b1; ce = 1'b1;
    step();
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [10:0] a);
    addr = a; we = 1'b0; ce = 1'b1;
    step();
    ce = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ce = 1'b0; we = 1'b0; addr = '0;
    data_in = '0; dev_rdata = '0; dev_irq = '0;
    step(); step();
    checks++; if (d1_dout !== 8'hFF) begin errors++; $display("FAIL rst_dout1: got %h want ff", d1_dout); end
    checks++; if (d3_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy3: got %b want 1", d3_rdy); end
    checks++; if (d1_irq !== 1'b0) begin errors++; $display("FAIL rst_irq1: got %b want 0", d1_irq); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_read_lat1();
    dev_rdata = 32'h0000_005A;
    addr = 11'h010; we = 1'b0; ce = 1'b1; #1;
    checks++; if (d1_stb !== 4'b0001) begin errors++; $display("FAIL lat1_stb: got %b want 0001", d1_stb); end
    step(); ce = 1'b0; #1;
    checks++; if (d1_stb !== 4'b0000) begin errors++; $display("FAIL lat1_stb_off: got %b want 0000", d1_stb); end
    checks++; if (d1_dout !== 8'h5A) begin errors++; $display("FAIL lat1_dout: got %h want 5a", d1_dout); end
    checks++; if (d1_rdy !== 1'b1) begin errors++; $display("FAIL lat1_rdy: got %b want 1", d1_rdy); end
    idle(3);
  endtask

  task automatic test_read_lat3();
    dev_rdata = 32'h00C3_005A;
    addr = 11'h040; we = 1'b0; ce = 1'b1; #1;
    checks++; if (d3_stb !== 4'b0100) begin errors++; $display("FAIL lat3_stb: got %b want 0100", d3_stb); end
    step(); #1;
    checks++; if (d3_rdy !== 1'b0) begin errors++; $display("FAIL lat3_rdy_t1: got %b want 0", d3_rdy); end
    checks++; if (d3_stb !== 4'b0000) begin errors++; $display("FAIL lat3_wait_stb: got %b want 0000", d3_stb); end
    step(); ce = 1'b0;
    checks++; if (d3_rdy !== 1'b0) begin errors++; $display("FAIL lat3_rdy_t2: got %b want 0", d3_rdy); end
    checks++; if (d3_dout !== 8'h5A) begin errors++; $display("FAIL lat3_hold: got %h want 5a", d3_dout); end
    step();
    checks++; if (d3_rdy !== 1'b1) begin errors++; $display("FAIL lat3_rdy_t3: got %b want 1", d3_rdy); end
    checks++; if (d3_dout !== 8'hC3) begin errors++; $display("FAIL lat3_dout: got %h want c3", d3_dout); end
    idle(3);
  endtask

  task automatic test_alias();
    dev_rdata = 32'h0000_3CF0;
    addr = 11'h030; we = 1'b0; ce = 1'b1; #1;
    checks++; if (d1_stb !== 4'b0011) begin errors++; $display("FAIL alias_rd_stb: got %b want 0011", d1_stb); end
    step();
    addr = 11'h035; we = 1'b1; data_in = 8'hAB; #1;
    checks++; if (d1_dout !== 8'h30) begin errors++; $display("FAIL alias_dout: got %h want 30", d1_dout); end
    checks++; if (d1_stb !== 4'b0011) begin errors++; $display("FAIL alias_wr_stb: got %b want 0011", d1_stb); end
    checks++; if (d1_we !== 1'b1) begin errors++; $display("FAIL pass_we: got %b want 1", d1_we); end
    checks++; if (d1_daddr !== 4'h5) begin errors++; $display("FAIL pass_addr: got %h want 5", d1_daddr); end
    checks++; if (d1_wdata !== 8'hAB) begin errors++; $display("FAIL pass_wdata: got %h want ab", d1_wdata); end
    step();
    idle(3);
  endtask

  task automatic test_edge_irq();
    wr(11'h002, 8'h01);
    wr(11'h001, 8'h01);
    dev_irq = 4'b0001;
    step();
    dev_irq = 4'b0000;
    checks++; if (d1_irq !== 1'b1) begin errors++; $display("FAIL edge_irq: got %b want 1", d1_irq); end
    step();
    checks++; if (d1_irq !== 1'b1) begin errors++; $display("FAIL edge_irq_held: got %b want 1", d1_irq); end
    rd(11'h000);
    checks++; if (d1_dout !== 8'h01) begin errors++; $display("FAIL edge_pend: got %h want 01", d1_dout); end
    dev_irq = 4'b0001;
    wr(11'h003, 8'h01);
    checks++; if (d1_irq !== 1'b1) begin errors++; $display("FAIL set_wins: got %b want 1", d1_irq); end
    dev_irq = 4'b0000;
    rd(11'h000);
    checks++; if (d1_dout !== 8'h01) begin errors++; $display("FAIL set_wins_pend: got %h want 01", d1_dout); end
    wr(11'h003, 8'h01);
    checks++; if (d1_irq !== 1'b0) begin errors++; $display("FAIL clear_irq: got %b want 0", d1_irq); end
    rd(11'h003);
    checks++; if (d1_dout !== 8'h00) begin errors++; $display("FAIL clear_rd: got %h want 00", d1_dout); end
  endtask

  task automatic test_level_irq();
    wr(11'h002, 8'h00);
    wr(11'h001, 8'h00);
    dev_irq = 4'b0010;
    step();
    rd(11'h000);
    checks++; if (d1_dout !== 8'h02) begin errors++; $display("FAIL level_pend: got %h want 02", d1_dout); end
    checks++; if (d1_irq !== 1'b0) begin errors++; $display("FAIL level_masked: got %b want 0", d1_irq); end
    wr(11'h001, 8'h02);
    checks++; if (d1_irq !== 1'b1) begin errors++; $display("FAIL level_unmask: got %b want 1", d1_irq); end
    rd(11'h001);
    checks++; if (d1_dout !== 8'h02) begin errors++; $display("FAIL mask_rd: got %h want 02", d1_dout); end
    dev_irq = 4'b0000;
    wr(11'h002, 8'h01);
    dev_irq = 4'b0001;
    step();
    dev_irq = 4'b0000;
    wr(11'h002, 8'h00);
    rd(11'h000);
    checks++; if (d1_dout !== 8'h00) begin errors++; $display("FAIL mode_discard: got %h want 00", d1_dout); end
  endtask

  task automatic test_unmapped();
    logic [7:0] exp;
`ifdef PET_IO_OPENBUS_EN
    exp = 8'h77;
`else
    exp = 8'hFF;
`endif
    idle(3);
    wr(11'h010, 8'h77);
    addr = 11'h400; we = 1'b0; ce = 1'b1; #1;
    checks++; if (d1_stb !== 4'b0000) begin errors++; $display("FAIL unmap_stb: got %b want 0000", d1_stb); end
    step(); ce = 1'b0;
    checks++; if (d1_dout !== exp) begin errors++; $display("FAIL unmap_dout: got %h want %h", d1_dout, exp); end
  endtask

  task automatic test_reset_midwait();
    idle(3);
    dev_rdata = 32'h00C3_0000;
    rd(11'h040);
    checks++; if (d3_rdy !== 1'b0) begin errors++; $display("FAIL mid_wait_rdy: got %b want 0", d3_rdy); end
    reset_n = 1'b0; #1;
    checks++; if (d3_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_rdy: got %b want 1", d3_rdy); end
    checks++; if (d3_dout !== 8'hFF) begin errors++; $display("FAIL mid_rst_dout: got %h want ff", d3_dout); end
    step();
    reset_n = 1'b1;
    step(); step();
    checks++; if (d3_dout !== 8'hFF) begin errors++; $display("FAIL mid_rst_abandon: got %h want ff", d3_dout); end
    dev_irq = 4'b0100;
    step();
    checks++; if (d1_irq !== 1'b1) begin errors++; $display("FAIL rst_mask_ones: got %b want 1", d1_irq); end
    rd(11'h000);
    checks++; if (d1_dout !== 8'h04) begin errors++; $display("FAIL rst_pend: got %h want 04", d1_dout); end
    dev_irq = 4'b0000;
    step();
  endtask

  initial begin
    test_reset();
    test_read_lat1();
    test_read_lat3();
    test_alias();
    test_edge_irq();
    test_level_irq();
    test_unmapped();
    test_reset_midwait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pet_io_hub.md
Name: pet_io_hub

Overview:
- Parametrised I/O region hub for the PET core. Replaces fixed PIA1/PIA2/VIA glue with NUM_DEV generic device slots.
- Slot decode is one-hot, PET-style: slot i is hit by address bit SLOT_AW+i. With the defaults this gives E810/E820/E840/E880.
- Provides a registered read mux with programmable read latency and an RDY wait handshake.
- Includes an internal interrupt controller with per-source mask, level/edge mode and pending clear.
- Sits between the CPU bus and the peripheral instances (pia6520, via6522, future devices).

Parameters:
- NUM_DEV, 4, number of device slots; 1..8; must be <= ADDR_W-SLOT_AW.
- ADDR_W, 11, width of the I/O region address.
- SLOT_AW, 4, low address bits passed through to devices; slot granularity is 2^SLOT_AW.
- RD_LAT, 1, cycles from read acceptance to valid data_out; 1..4.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- ce  in  1  CPU bus cycle enable (one-cycle access qualifier).
- addr  in  ADDR_W  CPU address within the I/O region.
- we  in  1  write enable; 0 = read.
- data_in  in  8  CPU write data.
- data_out  out  8  registered read data.
- rdy  out  1  1 = hub can accept an access; 0 = read wait state.
- irq  out  1  aggregated masked interrupt.
- dev_strobe  out  NUM_DEV  per-slot access strobe (combinational).
- dev_we  out  1  write enable forwarded to devices.
- dev_addr  out  SLOT_AW  low address forwarded to devices.
- dev_wdata  out  8  write data forwarded to devices.
- dev_rdata  in  8*NUM_DEV  device read data; slot i occupies bits [8i+7:8i].
- dev_irq  in  NUM_DEV  device interrupt requests, active high, synchronous to clk.

Behaviour:
- Reset values: data_out=8'hFF, rdy=1, irq=0, mask=all ones (equivalent to a plain OR of all sources), mode=all level, pending=0, wait counter=0.
- Access acceptance: an access is accepted when ce=1 and rdy=1. While rdy=0, ce is ignored: no strobe, no register effect.
- Decode, with hb = addr[ADDR_W-1:SLOT_AW]:
  - dev_strobe[i] = accepted & hb[i].
  - Multiple hb bits set: all hit slots are strobed (PET alias behaviour). Read data is the bitwise AND of the hit slots' dev_rdata.
  - hb==0 selects the internal IRQ controller.
  - Bits of hb above NUM_DEV set, with no slot hit: unmapped; writes are dropped; reads return 8'hFF.
- Pass-through: dev_we, dev_addr and dev_wdata are combinational copies of we, addr[SLOT_AW-1:0] and data_in.
- Read pipeline:
  - dev_rdata is sampled on the edge ending acceptance cycle T.
  - data_out becomes valid at T+RD_LAT and holds until the next read completes.
  - rdy=0 during cycles T+1..T+RD_LAT-1 via a down-counter. With RD_LAT=1, rdy never drops.
  - Writes never drop rdy.
- IRQ controller registers (addr[1:0] at hb==0; addr[SLOT_AW-1:2] ignored):
  - 0 PEND: read returns pending; writes are ignored.
  - 1 MASK: read/write.
  - 2 MODE: read/write; 1 = edge.
  - 3 CLEAR: write-1-to-clear of edge-pending bits; reads return 0.
  - Unused upper bits read 0.
- Pending:
  - Level source: pending[i]=dev_irq[i], no latch.
  - Edge source: set on a 0->1 transition of dev_irq (previous-value register); cleared by CLEAR.
  - Simultaneous set and clear: set wins.
  - MODE change edge->level discards the latched bit.
- irq = |(pending & mask), registered; 1-cycle latency from dev_irq.
- Asynchronous reset_n assertion mid-read: the counter clears, rdy=1 immediately, and the pending read is abandoned.

Optional Feature:
- Macro PET_IO_OPENBUS_EN.
- Defined: the hub keeps a bus-latch register, reset to 8'hFF, updated with data_in on every accepted write and with the returned data on every completed read. Unmapped reads return the bus-latch value, emulating an open NMOS bus.
- Undefined: unmapped reads return 8'hFF and no latch register exists.

Decomposition:
- Package pet_io_pkg: IRQ register offsets (PEND=0, MASK=1, MODE=2, CLEAR=3), UNMAPPED_DATA=8'hFF, and a MAX_DEV=8 constant used for the parameter check.
- One natural sub-module, pet_io_irqctl: holds mask, mode, pending and edge detect, and produces irq plus its register read data.

Test Plan:
- RD_LAT=1, dev_rdata slot0=8'h5A; read addr 11'h010 -> dev_strobe=4'b0001 for one cycle, data_out=8'h5A next cycle, rdy stays 1.
- RD_LAT=3; read addr 11'h040 with slot2=8'hC3 -> rdy=0 for 2 cycles; a ce during the wait gives no strobe; data_out=8'hC3 at T+3.
- Read addr 11'h030 with slot0=8'hF0 and slot1=8'h3C -> both strobes set, data_out=8'h30. Write to 11'h030 -> both strobes set.
- Write MODE=8'h01 and MASK=8'h01, then pulse dev_irq[0] for 1 cycle -> PEND bit0=1 and irq=1 held. Write CLEAR=8'h01 on the same cycle as a new rising edge -> bit stays 1. A later CLEAR with no edge -> irq=0.
- Level source 1, MASK=8'h00, dev_irq[1]=1 -> PEND reads 8'h02, irq=0. Set MASK=8'h02 -> irq=1 one cycle later.
- Unmapped read 11'h400 after a write of 8'h77 to 11'h010 -> 8'h77 with PET_IO_OPENBUS_EN, 8'hFF without. Reset mid-wait -> rdy=1 and data_out=8'hFF.
